// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
package regfile_pkg;

  localparam int unsigned DEFAULT_ADDRESS_WIDTH = 5;
  localparam int unsigned DEFAULT_DATA_WIDTH    = 32;

  // Register 0 is hard-wired; writes to it are dropped.
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of writeback, multi-cycle result, issue and register-file write signals.
interface regfile_write_arbiter_if
  import regfile_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH    = 2
);

  localparam int unsigned NUM_REGS    = 2 ** ADDRESS_WIDTH;
  localparam int unsigned COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

  logic                     wb_valid;
  logic [ADDRESS_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0]    wb_data;

  logic                     mu_valid;
  logic                     mu_ready;
  logic [ADDRESS_WIDTH-1:0] mu_addr;
  logic [DATA_WIDTH-1:0]    mu_data;

  logic                     issue_valid;
  logic [ADDRESS_WIDTH-1:0] issue_addr;

  logic                     rf_we;
  logic [ADDRESS_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0]    rf_wdata;

  logic [NUM_REGS-1:0]      busy_mask;
  logic                     hold_pipe;
  logic [COUNT_WIDTH-1:0]   fifo_count;

  // Pipeline / hazard-unit side.
  modport master (
    output wb_valid, wb_addr, wb_data,
    output mu_valid, mu_addr, mu_data,
    output issue_valid, issue_addr,
    input  mu_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  busy_mask, hold_pipe, fifo_count
  );

  // Arbiter side.
  modport slave (
    input  wb_valid, wb_addr, wb_data,
    input  mu_valid, mu_addr, mu_data,
    input  issue_valid, issue_addr,
    output mu_ready,
    output rf_we, rf_waddr, rf_wdata,
    output busy_mask, hold_pipe, fifo_count
  );

endinterface

// File: rtl/regfile_write_arbiter_result_fifo.sv
// Synchronous FIFO of {addr, data} multi-cycle results; head is read combinationally.
module result_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH         = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               push,
  input  logic [ADDRESS_WIDTH-1:0]           push_addr,
  input  logic [DATA_WIDTH-1:0]              push_data,
  input  logic                               pop,
  output logic [ADDRESS_WIDTH-1:0]           head_addr,
  output logic [DATA_WIDTH-1:0]              head_data,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(DEPTH):0]             count
);

  localparam int unsigned PTR_WIDTH   = $clog2(DEPTH);
  localparam int unsigned COUNT_WIDTH = PTR_WIDTH + 1;

  logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0]    data_mem [DEPTH];
  logic [PTR_WIDTH-1:0]     wr_ptr;
  logic [PTR_WIDTH-1:0]     rd_ptr;
  logic [COUNT_WIDTH-1:0]   count_q;
  logic                     do_push;
  logic                     do_pop;

  assign full      = (count_q == COUNT_WIDTH'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // A push into a full FIFO is taken only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + COUNT_WIDTH'(1);
        2'b01:   count_q <= count_q - COUNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between writeback (priority) and queued
// multi-cycle results, tracks pending destinations, and forces a FIFO drain
// cycle when the head has been starved too long.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  regfile_write_arbiter_if.slave bus
);

  localparam int unsigned NUM_REGS     = 2 ** ADDRESS_WIDTH;
  localparam int unsigned COUNT_WIDTH  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned STARVE_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR  = ADDRESS_WIDTH'(REG_ZERO);
  localparam logic [STARVE_WIDTH-1:0]  STARVE_TOP = STARVE_WIDTH'(STARVE_LIMIT - 1);

  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [COUNT_WIDTH-1:0]   fifo_count;
  logic [ADDRESS_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0]    head_data;

  logic                     mu_ready;
  logic                     wb_win;

  logic                     rf_we;
  logic [ADDRESS_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0]    rf_wdata;

  arb_state_t               state;
  arb_state_t               state_next;
  logic [STARVE_WIDTH-1:0]  starve_cnt;
  logic [STARVE_WIDTH-1:0]  starve_next;
  logic                     hold_q;

  logic [NUM_REGS-1:0]      busy_q;
  logic [NUM_REGS-1:0]      busy_next;
  logic [NUM_REGS-1:0]      set_mask;
  logic [NUM_REGS-1:0]      clr_mask;

  // Readiness reflects fullness before any same-cycle pop; forced low in reset.
  assign mu_ready  = rst_n && !fifo_full;
  // Results for r0 complete the handshake but are not queued.
  assign fifo_push = bus.mu_valid && mu_ready && (bus.mu_addr != ZERO_ADDR);
  assign wb_win    = bus.wb_valid && (bus.wb_addr != ZERO_ADDR);

  result_fifo #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .DEPTH         (FIFO_DEPTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_addr (bus.mu_addr),
    .push_data (bus.mu_data),
    .pop       (fifo_pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Grant mux. WB keeps the port even in FORCE: a writeback arriving despite
  // hold_pipe is written rather than lost, and the head simply waits.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = head_addr;
    rf_wdata = head_data;
    fifo_pop = 1'b0;
    if (rst_n) begin
      if (wb_win) begin
        rf_we    = 1'b1;
        rf_waddr = bus.wb_addr;
        rf_wdata = bus.wb_data;
      end else if (!fifo_empty) begin
        rf_we    = 1'b1;
        fifo_pop = 1'b1;
      end
    end
  end

  // Starvation FSM next state: count consecutive cycles the head loses to WB.
  always_comb begin
    state_next  = state;
    starve_next = starve_cnt;
    case (state)
      NORMAL: begin
        if (fifo_empty || fifo_pop) begin
          starve_next = '0;
        end else if (wb_win) begin
          if (starve_cnt == STARVE_TOP) begin
            state_next  = FORCE;
            starve_next = '0;
          end else begin
            starve_next = starve_cnt + STARVE_WIDTH'(1);
          end
        end
      end
      FORCE: begin
        state_next  = NORMAL;
        starve_next = '0;
      end
      default: begin
        state_next  = NORMAL;
        starve_next = '0;
      end
    endcase
  end

  // Starvation FSM state register; hold_pipe is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= NORMAL;
      starve_cnt <= '0;
      hold_q     <= 1'b0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
      hold_q     <= (state_next == FORCE);
    end
  end

  // Busy-mask update: drained FIFO entries clear, issues set; set wins on overlap.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.issue_valid && (bus.issue_addr != ZERO_ADDR)) begin
      set_mask = NUM_REGS'(1) << bus.issue_addr;
    end
    if (fifo_pop) begin
      clr_mask = NUM_REGS'(1) << head_addr;
    end
    busy_next = (busy_q & ~clr_mask) | set_mask;
  end

  // Busy-mask register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  assign bus.mu_ready   = mu_ready;
  assign bus.rf_we      = rf_we;
  assign bus.rf_waddr   = rf_waddr;
  assign bus.rf_wdata   = rf_wdata;
  assign bus.busy_mask  = busy_q;
  assign bus.hold_pipe  = hold_q;
  assign bus.fifo_count = fifo_count;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_regfile_write_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .FIFO_DEPTH    (DEPTH)
  ) bus ();

  regfile_write_arbiter #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .FIFO_DEPTH    (DEPTH),
    .STARVE_LIMIT  (LIMIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Reference model: pending results in arrival order, pending-register set,
  // length of the current run of cycles the head lost to WB, and a one-shot hold.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_busy;
  int          m_run;
  bit          m_force;

  int n_checks = 0;
  int n_errors = 0;

  // Observed values of the most recent step, for directed literal checks.
  logic          obs_we;
  logic [AW-1:0] obs_waddr;
  logic [DW-1:0] obs_wdata;
  logic          obs_ready;
  logic          obs_hold;
  logic [31:0]   obs_busy;
  logic [1:0]    obs_count;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy  = '0;
    m_run   = 0;
    m_force = 1'b0;
  endtask

  task automatic drive_idle();
    bus.wb_valid    = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
    bus.mu_valid    = 1'b0;
    bus.mu_addr     = '0;
    bus.mu_data     = '0;
    bus.issue_valid = 1'b0;
    bus.issue_addr  = '0;
  endtask

  // One clock cycle: drive, check every output against the model, advance the model.
  task automatic step(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                      input bit iv, input logic [AW-1:0] ia);
    bit            exp_ready;
    bit            wb_ok;
    bit            exp_we;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    bit            had_entries;
    @(negedge clk);
    bus.wb_valid    = wv;
    bus.wb_addr     = wa;
    bus.wb_data     = wd;
    bus.mu_valid    = mv;
    bus.mu_addr     = ma;
    bus.mu_data     = md;
    bus.issue_valid = iv;
    bus.issue_addr  = ia;
    #1;
    exp_ready   = (q.size() < DEPTH);
    wb_ok       = wv && (wa != 0);
    had_entries = (q.size() > 0);
    exp_we      = 1'b0;
    exp_a       = '0;
    exp_d       = '0;
    if (wb_ok) begin
      exp_we = 1'b1; exp_a = wa; exp_d = wd;
    end else if (had_entries) begin
      exp_we = 1'b1; exp_a = q[0].a; exp_d = q[0].d;
    end

    obs_we    = bus.rf_we;
    obs_waddr = bus.rf_waddr;
    obs_wdata = bus.rf_wdata;
    obs_ready = bus.mu_ready;
    obs_hold  = bus.hold_pipe;
    obs_busy  = bus.busy_mask;
    obs_count = bus.fifo_count;

    check("mu_ready", 64'(obs_ready), 64'(exp_ready));
    check("hold_pipe", 64'(obs_hold), 64'(m_force));
    check("busy_mask", 64'(obs_busy), 64'(m_busy));
    check("fifo_count", 64'(obs_count), 64'(q.size()));
    check("rf_we", 64'(obs_we), 64'(exp_we));
    if (exp_we) begin
      check("rf_waddr", 64'(obs_waddr), 64'(exp_a));
      check("rf_wdata", 64'(obs_wdata), 64'(exp_d));
    end
    if (iv && ia != 0) check("issue_to_busy", 64'(obs_busy[ia]), 64'd0);

    // Advance the model to the state after this clock edge.
    if (!wb_ok && had_entries) begin
      m_busy[q[0].a] = 1'b0;
      void'(q.pop_front());
    end
    if (m_force) begin
      m_force = 1'b0;
      m_run   = 0;
    end else if (wb_ok && had_entries) begin
      m_run++;
      if (m_run == LIMIT) begin
        m_force = 1'b1;
        m_run   = 0;
      end
    end else begin
      m_run = 0;
    end
    if (mv && exp_ready && ma != 0) q.push_back('{a: ma, d: md});
    if (iv && ia != 0) m_busy[ia] = 1'b1;
  endtask

  task automatic idle_step();
    step(0, '0, '0, 0, '0, '0, 0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  bit            rv_wv, rv_mv, rv_iv;
  logic [AW-1:0] rv_wa, rv_ma, rv_ia;
  logic [DW-1:0] rv_wd, rv_md;
  int            wb_pct;

  initial begin
    // Reset with requests present: port and handshake must stay quiet.
    drive_idle();
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 5'd3;
    bus.wb_data  = 32'h1234;
    bus.mu_valid = 1'b1;
    bus.mu_addr  = 5'd4;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check("reset_rf_we", 64'(bus.rf_we), 64'd0);
      check("reset_mu_ready", 64'(bus.mu_ready), 64'd0);
      check("reset_busy", 64'(bus.busy_mask), 64'd0);
    end
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    idle_step();
    check("post_reset_ready", 64'(obs_ready), 64'd1);
    check("post_reset_count", 64'(obs_count), 64'd0);

    // Lone multi-cycle result.
    step(0, '0, '0, 0, '0, '0, 1, 5'd5);
    step(0, '0, '0, 1, 5'd5, 32'hDEAD, 0, '0);
    check("lone_busy5_set", 64'(obs_busy[5]), 64'd1);
    idle_step();
    check("lone_we", 64'(obs_we), 64'd1);
    check("lone_waddr", 64'(obs_waddr), 64'd5);
    check("lone_wdata", 64'(obs_wdata), 64'hDEAD);
    idle_step();
    check("lone_busy5_clr", 64'(obs_busy[5]), 64'd0);

    // Contention: WB every cycle while two results queue up.
    step(0, '0, '0, 0, '0, '0, 1, 5'd10);
    step(0, '0, '0, 0, '0, '0, 1, 5'd11);
    step(1, 5'd1, 32'h101, 1, 5'd10, 32'hA10, 0, '0);
    step(1, 5'd2, 32'h102, 1, 5'd11, 32'hA11, 0, '0);
    step(1, 5'd3, 32'h103, 1, 5'd12, 32'hA12, 0, '0);
    check("cont_full_ready", 64'(obs_ready), 64'd0);
    check("cont_wb_we", 64'(obs_waddr), 64'd3);
    step(1, 5'd4, 32'h104, 0, '0, '0, 0, '0);
    step(1, 5'd5, 32'h105, 0, '0, '0, 0, '0);
    check("cont_no_hold_yet", 64'(obs_hold), 64'd0);
    idle_step();
    check("cont_hold", 64'(obs_hold), 64'd1);
    check("cont_force_waddr", 64'(obs_waddr), 64'd10);
    check("cont_force_wdata", 64'(obs_wdata), 64'hA10);
    step(1, 5'd6, 32'h106, 0, '0, '0, 0, '0);
    check("cont_hold_drop", 64'(obs_hold), 64'd0);
    step(1, 5'd7, 32'h107, 0, '0, '0, 0, '0);
    step(1, 5'd8, 32'h108, 0, '0, '0, 0, '0);
    repeat (2) idle_step();

    // Address 0 on both sources.
    step(1, 5'd0, 32'h1, 1, 5'd0, 32'h2, 0, '0);
    check("r0_we", 64'(obs_we), 64'd0);
    check("r0_ready", 64'(obs_ready), 64'd1);
    idle_step();
    check("r0_count", 64'(obs_count), 64'd0);
    check("r0_we_after", 64'(obs_we), 64'd0);

    // Full FIFO with push attempt and pop in the same cycle.
    step(0, '0, '0, 0, '0, '0, 1, 5'd20);
    step(0, '0, '0, 0, '0, '0, 1, 5'd21);
    step(1, 5'd1, 32'h201, 1, 5'd20, 32'hB20, 1, 5'd22);
    step(1, 5'd2, 32'h202, 1, 5'd21, 32'hB21, 0, '0);
    step(0, '0, '0, 1, 5'd22, 32'hB22, 0, '0);
    check("full_ready", 64'(obs_ready), 64'd0);
    check("full_pop_addr", 64'(obs_waddr), 64'd20);
    step(0, '0, '0, 1, 5'd22, 32'hB22, 0, '0);
    check("full_next_ready", 64'(obs_ready), 64'd1);
    check("full_pop2_addr", 64'(obs_waddr), 64'd21);
    idle_step();
    check("full_order_addr", 64'(obs_waddr), 64'd22);
    check("full_order_data", 64'(obs_wdata), 64'hB22);
    idle_step();

    // Reset mid-run with two queued entries and busy[7] set.
    step(0, '0, '0, 0, '0, '0, 1, 5'd7);
    step(0, '0, '0, 0, '0, '0, 1, 5'd9);
    step(1, 5'd1, 32'h301, 1, 5'd7, 32'hC07, 0, '0);
    step(1, 5'd2, 32'h302, 1, 5'd9, 32'hC09, 0, '0);
    @(negedge clk);
    drive_idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_count", 64'(bus.fifo_count), 64'd0);
    check("midrst_busy", 64'(bus.busy_mask), 64'd0);
    check("midrst_we", 64'(bus.rf_we), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      idle_step();
      check("midrst_no_r7", 64'(obs_we), 64'd0);
    end

    // Randomized traffic: moderate then heavy writeback load.
    for (int i = 0; i < 400; i++) begin
      wb_pct = (i < 200) ? 55 : 90;
      rv_wv  = ($urandom_range(0, 99) < wb_pct);
      rv_wa  = AW'($urandom_range(0, 31));
      rv_wd  = $urandom();
      rv_mv  = ($urandom_range(0, 1) == 1);
      rv_ma  = ($urandom_range(0, 9) == 0) ? '0 : AW'($urandom_range(1, 31));
      rv_md  = $urandom();
      rv_iv  = ($urandom_range(0, 2) == 0);
      rv_ia  = AW'($urandom_range(1, 31));
      if (m_busy[rv_ia]) rv_iv = 1'b0;
      step(rv_wv, rv_wa, rv_wd, rv_mv, rv_ma, rv_md, rv_iv, rv_ia);
    end
    repeat (4) idle_step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
